// File: rtl/polaris_ifetch_pkg.sv
// Shared definitions for the instruction-fetch bridge: FSM state encoding,
// CPU fetch-size codes and the watchdog expiry count.
package polaris_ifetch_pkg;

    // Bridge FSM states: waiting, low beat, high beat, acknowledge to CPU
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_ACK  = 2'b11
    } ifetch_state_t;

    // CPU fetch-size encodings; 2'b11 is reserved and behaves as a word
    localparam logic [1:0] ISIZ_NONE = 2'b00;
    localparam logic [1:0] ISIZ_HALF = 2'b01;
    localparam logic [1:0] ISIZ_WORD = 2'b10;

    // Number of consecutive un-acknowledged bus cycles before a fetch aborts
    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

    // True when the fetch needs both 16-bit beats
    function automatic logic is_word_fetch(input logic [1:0] siz);
        logic word;
        case (siz)
            ISIZ_HALF: word = 1'b0;
            ISIZ_WORD: word = 1'b1;
            default:   word = 1'b1;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/ifetch_bridge_if.sv
// Signal bundle between the CPU fetch port, the bridge and the 16-bit
// Wishbone classic bus. The master modport is the bridge's view; the slave
// modport is the view of the surrounding CPU/bus environment.
interface ifetch_bridge_if;

    logic [63:0] iadr_i;
    logic [1:0]  isiz_i;
    logic        iack_o;
    logic [31:0] idat_o;
    logic        ierr_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [63:0] wb_adr_o;
    logic [15:0] wb_dat_i;
    logic        wb_ack_i;

    modport master (
        input  iadr_i,
        input  isiz_i,
        output iack_o,
        output idat_o,
        output ierr_o,
        output wb_cyc_o,
        output wb_stb_o,
        output wb_adr_o,
        input  wb_dat_i,
        input  wb_ack_i
    );

    modport slave (
        output iadr_i,
        output isiz_i,
        input  iack_o,
        input  idat_o,
        input  ierr_o,
        input  wb_cyc_o,
        input  wb_stb_o,
        input  wb_adr_o,
        output wb_dat_i,
        output wb_ack_i
    );

endinterface

// File: rtl/ifetch_watchdog.sv
// Bus-stall watchdog for the fetch bridge. Counts bus cycles that pass
// without an acknowledge and flags expiry once TIMEOUT_LIMIT is reached.
// Only instantiated when IFETCH_TIMEOUT_EN is defined.
module ifetch_watchdog
    import polaris_ifetch_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expire_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Clear wins over counting; the count saturates at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (count_en_i && (cnt_q != TIMEOUT_LIMIT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == TIMEOUT_LIMIT);

endmodule

// File: rtl/ifetch_bridge.sv
// Instruction-fetch bridge: turns a CPU halfword/word fetch into one or two
// 16-bit Wishbone classic read beats (low halfword first, cyc held across
// both beats) and returns the result with a one-cycle iack_o strobe.
// Optional stall watchdog enabled by defining IFETCH_TIMEOUT_EN; without it
// the bridge waits indefinitely for the bus and ierr_o is tied to 0.
module ifetch_bridge
    import polaris_ifetch_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    ifetch_bridge_if.master  bus
);

    ifetch_state_t state_q, state_d;
    logic [63:0]   base_q, base_d;
    logic          word_q, word_d;
    logic [15:0]   lo_q, lo_d;
    logic [31:0]   idat_q, idat_d;
    logic          err_q, err_d;

    logic          in_beat;
    logic          beat_ack;
    logic          expired;

    assign in_beat  = (state_q == ST_LO) || (state_q == ST_HI);
    assign beat_ack = in_beat && bus.wb_ack_i;

`ifdef IFETCH_TIMEOUT_EN
    logic wd_clear;
    logic wd_count;

    // Counter restarts while idle (so it is zero on entering LO) and on each beat ack
    assign wd_clear = (state_q == ST_IDLE) || beat_ack;
    assign wd_count = in_beat && !bus.wb_ack_i;

    ifetch_watchdog u_watchdog (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clear_i    (wd_clear),
        .count_en_i (wd_count),
        .expire_o   (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // Next-state logic: latch request in IDLE, collect beats, abort on expiry
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        word_d  = word_q;
        lo_d    = lo_q;
        idat_d  = idat_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (bus.isiz_i != ISIZ_NONE) begin
                    base_d  = {bus.iadr_i[63:1], 1'b0};
                    word_d  = is_word_fetch(bus.isiz_i);
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (bus.wb_ack_i) begin
                    lo_d = bus.wb_dat_i;
                    if (word_q) begin
                        state_d = ST_HI;
                    end else begin
                        idat_d  = {16'h0000, bus.wb_dat_i};
                        err_d   = 1'b0;
                        state_d = ST_ACK;
                    end
                end else if (expired) begin
                    idat_d  = 32'h0000_0000;
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_HI: begin
                if (bus.wb_ack_i) begin
                    idat_d  = {bus.wb_dat_i, lo_q};
                    err_d   = 1'b0;
                    state_d = ST_ACK;
                end else if (expired) begin
                    idat_d  = 32'h0000_0000;
                    err_d   = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any fetch in flight
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            base_q  <= 64'h0;
            word_q  <= 1'b0;
            lo_q    <= 16'h0;
            idat_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            word_q  <= word_d;
            lo_q    <= lo_d;
            idat_q  <= idat_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs decode directly from state; the high beat address wraps mod 2^64
    always_comb begin
        bus.wb_cyc_o = in_beat;
        bus.wb_stb_o = in_beat;
        bus.wb_adr_o = 64'h0;
        if (state_q == ST_LO) begin
            bus.wb_adr_o = base_q;
        end else if (state_q == ST_HI) begin
            bus.wb_adr_o = base_q + 64'd2;
        end
    end

    assign bus.iack_o = (state_q == ST_ACK);
    assign bus.idat_o = idat_q;
    assign bus.ierr_o = err_q && (state_q == ST_ACK);

endmodule

// File: tb/tb_ifetch_bridge.sv
// Directed self-checking bench for ifetch_bridge. A small behavioural
// Wishbone slave with programmable wait states answers the bus; expected
// values are hand-computed constants. Honours IFETCH_TIMEOUT_EN.
module tb_ifetch_bridge;

    logic clk;
    logic reset;

    ifetch_bridge_if bus ();

    ifetch_bridge dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural slave configuration
    int          slaveWaits  = 0;
    logic        slaveEnable = 1'b1;
    logic [63:0] loAddr      = 64'h0;
    logic [15:0] datLo       = 16'h0;
    logic [15:0] datHi       = 16'h0;
    logic [7:0]  waitCnt;
    int          iackCount;

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave wait-state counter restarts at each new beat
    always @(posedge clk) begin
        if (!bus.wb_stb_o || bus.wb_ack_i) begin
            waitCnt <= 8'd0;
        end else begin
            waitCnt <= waitCnt + 8'd1;
        end
    end

    // Counts every cycle in which the bridge acknowledges the CPU
    always @(posedge clk) begin
        if (reset === 1'b1 && iackCount === 0 && $time < 20) begin
            iackCount <= 0;
        end else if (bus.iack_o === 1'b1) begin
            iackCount <= iackCount + 1;
        end
    end

    assign bus.wb_ack_i = slaveEnable && bus.wb_stb_o && (int'(waitCnt) == slaveWaits);
    assign bus.wb_dat_i = (bus.wb_adr_o == loAddr) ? datLo : datHi;

    // One comparison: counts it, reports tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive a CPU request and advance to the next sampling point
    task automatic applyStimulus(input logic [63:0] adr, input logic [1:0] siz);
        bus.iadr_i = adr;
        bus.isiz_i = siz;
        @(negedge clk);
    endtask

    // Bounded wait for iack_o; an expired bound counts as a failure
    task automatic waitAck(input string tag, input int limit);
        int seen;
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            if (bus.iack_o === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checkOutput(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        int n;
        int iackBefore;

        iackCount  = 0;
        reset      = 1'b1;
        bus.iadr_i = 64'h0;
        bus.isiz_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_cyc",  64'(bus.wb_cyc_o), 64'd0);
        checkOutput("rst_stb",  64'(bus.wb_stb_o), 64'd0);
        checkOutput("rst_iack", 64'(bus.iack_o),   64'd0);
        checkOutput("rst_ierr", 64'(bus.ierr_o),   64'd0);
        checkOutput("rst_adr",  bus.wb_adr_o,      64'd0);
        checkOutput("rst_idat", 64'(bus.idat_o),   64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait word fetch near the top of memory
        $display("[TB] zero-wait word fetch");
        slaveWaits = 0;
        loAddr = 64'hFFFF_FFFF_FFFF_FF00;
        datLo  = 16'h0013;
        datHi  = 16'h0000;
        applyStimulus(64'hFFFF_FFFF_FFFF_FF00, 2'b10);
        bus.isiz_i = 2'b00;
        checkOutput("w_lo_cyc",  64'(bus.wb_cyc_o), 64'd1);
        checkOutput("w_lo_stb",  64'(bus.wb_stb_o), 64'd1);
        checkOutput("w_lo_adr",  bus.wb_adr_o, 64'hFFFF_FFFF_FFFF_FF00);
        checkOutput("w_lo_iack", 64'(bus.iack_o), 64'd0);
        @(negedge clk);
        checkOutput("w_hi_cyc",  64'(bus.wb_cyc_o), 64'd1);
        checkOutput("w_hi_adr",  bus.wb_adr_o, 64'hFFFF_FFFF_FFFF_FF02);
        @(negedge clk);
        checkOutput("w_ack_iack", 64'(bus.iack_o), 64'd1);
        checkOutput("w_ack_idat", 64'(bus.idat_o), 64'h0000_0013);
        checkOutput("w_ack_ierr", 64'(bus.ierr_o), 64'd0);
        checkOutput("w_ack_cyc",  64'(bus.wb_cyc_o), 64'd0);
        @(negedge clk);
        checkOutput("w_post_iack", 64'(bus.iack_o), 64'd0);
        checkOutput("w_post_idat", 64'(bus.idat_o), 64'h0000_0013);

        // Misaligned address at the top of memory wraps for the high beat
        $display("[TB] wrap and misalign");
        loAddr = 64'hFFFF_FFFF_FFFF_FFFE;
        datLo  = 16'h1111;
        datHi  = 16'hABCD;
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 2'b10);
        bus.isiz_i = 2'b00;
        checkOutput("wr_lo_adr", bus.wb_adr_o, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        checkOutput("wr_hi_adr", bus.wb_adr_o, 64'h0);
        checkOutput("wr_hi_cyc", 64'(bus.wb_cyc_o), 64'd1);
        @(negedge clk);
        checkOutput("wr_iack", 64'(bus.iack_o), 64'd1);
        checkOutput("wr_idat", 64'(bus.idat_o), 64'hABCD_1111);
        @(negedge clk);

        // Halfword fetch with two slave wait states
        $display("[TB] halfword with waits");
        slaveWaits = 2;
        loAddr = 64'h0000_0124;
        datLo  = 16'h8067;
        datHi  = 16'hDEAD;
        applyStimulus(64'h0000_0124, 2'b01);
        bus.isiz_i = 2'b00;
        checkOutput("h_n1_adr",  bus.wb_adr_o, 64'h124);
        checkOutput("h_n1_iack", 64'(bus.iack_o), 64'd0);
        @(negedge clk);
        checkOutput("h_n2_adr",  bus.wb_adr_o, 64'h124);
        checkOutput("h_n2_stb",  64'(bus.wb_stb_o), 64'd1);
        @(negedge clk);
        checkOutput("h_n3_adr",  bus.wb_adr_o, 64'h124);
        checkOutput("h_n3_iack", 64'(bus.iack_o), 64'd0);
        @(negedge clk);
        checkOutput("h_n4_iack", 64'(bus.iack_o), 64'd1);
        checkOutput("h_n4_idat", 64'(bus.idat_o), 64'h0000_8067);
        checkOutput("h_n4_cyc",  64'(bus.wb_cyc_o), 64'd0);
        @(negedge clk);
        checkOutput("h_n5_iack", 64'(bus.iack_o), 64'd0);

        // Address change after latch is ignored; held request restarts after one idle cycle
        $display("[TB] request stability");
        slaveWaits = 1;
        loAddr = 64'h1000;
        datLo  = 16'h5555;
        datHi  = 16'h6666;
        applyStimulus(64'h1000, 2'b10);
        checkOutput("s_n1_adr", bus.wb_adr_o, 64'h1000);
        bus.iadr_i = 64'h2000;
        @(negedge clk);
        checkOutput("s_n2_adr", bus.wb_adr_o, 64'h1000);
        @(negedge clk);
        checkOutput("s_n3_adr", bus.wb_adr_o, 64'h1002);
        @(negedge clk);
        checkOutput("s_n4_adr", bus.wb_adr_o, 64'h1002);
        @(negedge clk);
        checkOutput("s_n5_iack", 64'(bus.iack_o), 64'd1);
        checkOutput("s_n5_idat", 64'(bus.idat_o), 64'h6666_5555);
        @(negedge clk);
        checkOutput("s_idle_cyc",  64'(bus.wb_cyc_o), 64'd0);
        checkOutput("s_idle_iack", 64'(bus.iack_o), 64'd0);
        @(negedge clk);
        checkOutput("s_new_cyc", 64'(bus.wb_cyc_o), 64'd1);
        checkOutput("s_new_adr", bus.wb_adr_o, 64'h2000);
        bus.isiz_i = 2'b00;
        waitAck("s_new_ackwait", 20);
        @(negedge clk);

        // Reset held two cycles in the middle of the high beat
        $display("[TB] reset mid-fetch");
        slaveWaits = 3;
        loAddr = 64'h3000;
        applyStimulus(64'h3000, 2'b10);
        bus.isiz_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("r_hi_adr", bus.wb_adr_o, 64'h3002);
        iackBefore = iackCount;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("r_cyc",  64'(bus.wb_cyc_o), 64'd0);
        checkOutput("r_stb",  64'(bus.wb_stb_o), 64'd0);
        checkOutput("r_iack", 64'(bus.iack_o),   64'd0);
        checkOutput("r_adr",  bus.wb_adr_o,      64'd0);
        checkOutput("r_idat", 64'(bus.idat_o),   64'd0);
        for (int i = 0; i < 10; i++) @(negedge clk);
        checkOutput("r_no_iack", 64'(iackCount - iackBefore), 64'd0);
        checkOutput("r_idle_cyc", 64'(bus.wb_cyc_o), 64'd0);

        // Stalled slave: watchdog abort, or indefinite wait without it
        $display("[TB] stalled slave");
        slaveEnable = 1'b0;
        applyStimulus(64'h4000, 2'b10);
        bus.isiz_i = 2'b00;
`ifdef IFETCH_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.wb_cyc_o !== 1'b1) break;
            n++;
            @(negedge clk);
        end
        checkOutput("t_lo_cycles", 64'(n), 64'd256);
        checkOutput("t_iack", 64'(bus.iack_o), 64'd1);
        checkOutput("t_ierr", 64'(bus.ierr_o), 64'd1);
        checkOutput("t_idat", 64'(bus.idat_o), 64'd0);
        @(negedge clk);
        checkOutput("t_post_iack", 64'(bus.iack_o), 64'd0);
        checkOutput("t_post_ierr", 64'(bus.ierr_o), 64'd0);
`else
        iackBefore = iackCount;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            if (bus.wb_cyc_o === 1'b1) n++;
            @(negedge clk);
        end
        checkOutput("t_wait_cycles", 64'(n), 64'd1000);
        checkOutput("t_still_cyc", 64'(bus.wb_cyc_o), 64'd1);
        checkOutput("t_no_iack", 64'(iackCount - iackBefore), 64'd0);
        checkOutput("t_ierr", 64'(bus.ierr_o), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        slaveEnable = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
